// File: rtl/telemetry_framer_pkg.sv
// rtl/telemetry_framer_pkg.sv - shared types and constants for the telemetry frame builder
package telemetry_framer_pkg;

  localparam logic [7:0] HEADER_DEFAULT      = 8'hA5;
  localparam int         ACK_TIMEOUT_DEFAULT = 15;
  localparam int         FRAME_LEN           = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SEND      = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  localparam logic [2:0] IDX_HEADER = 3'd0;
  localparam logic [2:0] IDX_TS_3   = 3'd1;
  localparam logic [2:0] IDX_TS_2   = 3'd2;
  localparam logic [2:0] IDX_TS_1   = 3'd3;
  localparam logic [2:0] IDX_TS_0   = 3'd4;
  localparam logic [2:0] IDX_ADC    = 3'd5;
  localparam logic [2:0] IDX_FLAGS  = 3'd6;
  localparam logic [2:0] IDX_CSUM   = 3'd7;

  typedef struct packed {
    logic [25:0] tstamp;
    logic [7:0]  adc;
    logic        shut_down;
    logic        alarm;
  } snapshot_t;

endpackage

// File: rtl/telemetry_framer_frame_byte_mux.sv
// rtl/telemetry_framer_frame_byte_mux.sv - selects one frame byte from the snapshot or running checksum
module frame_byte_mux
  import telemetry_framer_pkg::*;
#(
  parameter logic [7:0] HEADER = HEADER_DEFAULT
) (
  input  logic [2:0]  sel,
  input  snapshot_t   snap,
  input  logic [7:0]  csum,
  output logic [7:0]  byte_out
);

  always_comb begin
    byte_out = 8'h00;
    case (sel)
      IDX_HEADER: byte_out = HEADER;
      IDX_TS_3:   byte_out = {6'b0, snap.tstamp[25:24]};
      IDX_TS_2:   byte_out = snap.tstamp[23:16];
      IDX_TS_1:   byte_out = snap.tstamp[15:8];
      IDX_TS_0:   byte_out = snap.tstamp[7:0];
      IDX_ADC:    byte_out = snap.adc;
      IDX_FLAGS:  byte_out = {6'b0, snap.shut_down, snap.alarm};
      IDX_CSUM:   byte_out = csum;
      default:    byte_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/telemetry_framer.sv
// rtl/telemetry_framer.sv - snapshots telemetry on trigger and streams an 8-byte frame to the UART
module telemetry_framer
  import telemetry_framer_pkg::*;
#(
  parameter logic [7:0] HEADER      = HEADER_DEFAULT,
  parameter int         ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trigger,
  input  logic [25:0] tstamp,
  input  logic [7:0]  adc_reading,
  input  logic        alarm,
  input  logic        shut_down,
  input  logic        tx_busy,
  input  logic        err_clr,
  output logic [7:0]  tx_data,
  output logic        tx_send,
  output logic        frame_active,
  output logic        overrun,
  output logic        ack_err
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  snapshot_t     snap;
  logic [2:0]    idx;
  logic [7:0]    csum;
  logic [CW-1:0] ack_cnt;
  logic [2:0]    next_sel;
  logic [7:0]    next_byte;

  // Byte 0 is a constant, so the mux can serve the accepting edge before snap is loaded.
  assign next_sel = (state == ST_IDLE) ? IDX_HEADER : idx + 3'd1;

  frame_byte_mux #(.HEADER(HEADER)) u_mux (
    .sel      (next_sel),
    .snap     (snap),
    .csum     (csum),
    .byte_out (next_byte)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      snap         <= '0;
      idx          <= '0;
      csum         <= '0;
      ack_cnt      <= '0;
      tx_data      <= '0;
      tx_send      <= 1'b0;
      frame_active <= 1'b0;
      overrun      <= 1'b0;
      ack_err      <= 1'b0;
    end else begin
      if (err_clr) begin
        overrun <= 1'b0;
        ack_err <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (trigger) begin
            snap         <= '{tstamp: tstamp, adc: adc_reading, shut_down: shut_down, alarm: alarm};
            idx          <= IDX_HEADER;
            csum         <= '0;
            frame_active <= 1'b1;
            tx_data      <= next_byte;
            tx_send      <= 1'b1;
            state        <= ST_SEND;
          end
        end
        ST_SEND: begin
          // tx_data still holds byte[idx], so fold it into the checksum here.
          tx_send <= 1'b0;
          if (idx != IDX_CSUM) csum <= csum ^ tx_data;
          ack_cnt <= '0;
          state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            state <= ST_WAIT_DONE;
          end else if (ack_cnt == CW'(ACK_TIMEOUT - 1)) begin
            ack_err      <= 1'b1;
            frame_active <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            ack_cnt <= ack_cnt + 1'b1;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) begin
            if (idx == IDX_CSUM) begin
              frame_active <= 1'b0;
              state        <= ST_IDLE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= next_byte;
              tx_send <= 1'b1;
              state   <= ST_SEND;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
      if (trigger && state != ST_IDLE) overrun <= 1'b1;
    end
  end

endmodule
